vx_dp_ram_ctrl: RTL and testbench
=================================

// Module: VX_dp_ram_ctrl
// PURPOSE
//   Shares one VX_dp_ram (1W/1R, byte-enabled) between NUM_REQS requesters. Independent
//   round-robin arbiters grant at most one write and one read per cycle. Read responses
//   are registered and back-pressured. After reset, an init FSM sweeps the RAM to
//   INIT_VALUE before any request is accepted. Sits in front of per-core scratch/tag RAMs.
// PARAMETERS
//   NUM_REQS    4              number of requesters (>=1)
//   DATAW       32             word width; ==8*BYTEENW when BYTEENW>1
//   SIZE        256            words in RAM (any value >=2, need not be a power of 2)
//   BYTEENW     4              byte enables; 1, or a multiple of 4
//   ADDRW       $clog2(SIZE)   address width
//   INIT_VALUE  0              word written to every address by the init sweep
//   REQ_IDXW    max(1,$clog2(NUM_REQS))  requester index width
// PORTS
//   clk        in   1                   clock
//   reset_n    in   1                   asynchronous, active-low reset
//   wr_valid   in   NUM_REQS            per-requester write request
//   wr_addr    in   NUM_REQS*ADDRW      write addresses, requester i at [i*ADDRW +: ADDRW]
//   wr_data    in   NUM_REQS*DATAW      write data, packed likewise
//   wr_byteen  in   NUM_REQS*BYTEENW    write byte enables, packed likewise
//   wr_ready   out  NUM_REQS            write grant (one-hot or zero)
//   rd_valid   in   NUM_REQS            per-requester read request
//   rd_addr    in   NUM_REQS*ADDRW      read addresses, packed
//   rd_ready   out  NUM_REQS            read grant (one-hot or zero)
//   rsp_valid  out  1                   read response valid
//   rsp_idx    out  REQ_IDXW            requester owning the response
//   rsp_data   out  DATAW               read data
//   rsp_ready  in   1                   response accepted
//   init_done  out  1                   init sweep finished, requests now served
// BEHAVIOUR
//   - Reset (async, reset_n=0): state=INIT, init_cnt=0, both RR pointers=0, rsp_valid=0,
//     rsp_idx=0, rsp_data=0, init_done=0; wr_ready=rd_ready=0 (combinationally gated).
//   - INIT: each cycle writes INIT_VALUE, all byte enables, at init_cnt; init_cnt++. At
//     init_cnt==SIZE-1 the write occurs and state->READY next edge. Exactly SIZE cycles;
//     init_done=1 registered in READY. Requests ignored, no ready asserted.
//   - READY write arb: grant lowest index i>=wr_ptr with wr_valid[i], else wrap to lowest
//     i<wr_ptr. wr_ready[i]=grant (comb. from wr_valid). On grant wr_ptr<=(i+1) mod
//     NUM_REQS; no grant -> wr_ptr holds. Granted write commits to RAM at the same edge.
//   - READY read arb: same RR scheme with rd_ptr, enabled only if slot free:
//     rd_en = !rsp_valid || rsp_ready. rd_en=0 -> rd_ready=0, rd_ptr holds.
//   - Read latency 1: RAM instanced OUT_REG=0; on read grant at edge: rsp_valid<=1,
//     rsp_idx<=i, rsp_data<=ram[rd_addr_i] (merged per bypass rule below).
//     rsp_valid && rsp_ready && no new grant -> rsp_valid<=0. While rsp_valid && !rsp_ready,
//     rsp_valid/idx/data held stable. Full throughput: one response per cycle.
//   - Same-cycle read and write, same address: see CONFIGURATION. Different addresses:
//     independent. Later reads always see committed writes.
//   - Reset mid-operation: pending response dropped, RR pointers reset, init sweep reruns
//     and overwrites all contents with INIT_VALUE.
//   - NUM_REQS=1: arbiters degenerate to pass-through gated by state/rd_en; rsp_idx=0.
// CONFIGURATION
//   VX_DP_RAM_CTRL_BYPASS_EN defined: same-cycle same-address read returns write data
//     merged bytewise per wr_byteen (enabled bytes new, others old) -> write-first.
//   Undefined: such a read returns the pre-write word (read-first); no forwarding logic.
// TESTING
//   1. SIZE=256, INIT_VALUE=0x5A5A5A5A, release reset_n -> init_done rises exactly 256
//      cycles later; read addr 0xFF -> rsp_data=0x5A5A5A5A, rsp_idx=requester.
//   2. Req0,req2 hold wr_valid -> wr_ready alternates 0,2,0,2; write 0xDEADBEEF byteen
//      4'b0011 over 0x11223344 at addr 5 -> later read returns 0x1122BEEF.
//   3. All 4 rd_valid held, rsp_ready=1 -> rsp_idx sequence 0,1,2,3,0 on consecutive cycles.
//   4. rsp_ready=0 for 3 cycles with rsp_valid=1 -> rsp_valid/idx/data stable, rd_ready=0;
//      rsp_ready=1 -> pending read granted same cycle, next response following edge.
//   5. Addr 9 holds 0xA; same cycle write 0xB and read 9 -> rsp_data 0xA without,
//      0xB with VX_DP_RAM_CTRL_BYPASS_EN; next read of 9 returns 0xB in both builds.
//   6. reset_n pulsed mid-traffic -> rsp_valid, init_done, readies drop immediately;
//      sweep reruns SIZE cycles; prior written addr 5 reads INIT_VALUE afterwards.

Source files
------------

// File: rtl/vx_dp_ram_ctrl_if.sv
// vx_dp_ram_ctrl_if: requester-side bus of vx_dp_ram_ctrl
// master (requesters): drives wr_valid/wr_addr/wr_data/wr_byteen, rd_valid/rd_addr, rsp_ready
// slave (controller):  drives wr_ready, rd_ready, rsp_valid/rsp_idx/rsp_data
// Per-requester fields are packed, requester i at [i*W +: W].
interface vx_dp_ram_ctrl_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int BYTEENW  = 4,
  parameter int ADDRW    = 8,
  parameter int REQ_IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
);
  logic [NUM_REQS-1:0]         wr_valid;
  logic [NUM_REQS*ADDRW-1:0]   wr_addr;
  logic [NUM_REQS*DATAW-1:0]   wr_data;
  logic [NUM_REQS*BYTEENW-1:0] wr_byteen;
  logic [NUM_REQS-1:0]         wr_ready;
  logic [NUM_REQS-1:0]         rd_valid;
  logic [NUM_REQS*ADDRW-1:0]   rd_addr;
  logic [NUM_REQS-1:0]         rd_ready;
  logic                        rsp_valid;
  logic [REQ_IDXW-1:0]         rsp_idx;
  logic [DATAW-1:0]            rsp_data;
  logic                        rsp_ready;
  modport master (
    output wr_valid, wr_addr, wr_data, wr_byteen, rd_valid, rd_addr, rsp_ready,
    input  wr_ready, rd_ready, rsp_valid, rsp_idx, rsp_data
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_byteen, rd_valid, rd_addr, rsp_ready,
    output wr_ready, rd_ready, rsp_valid, rsp_idx, rsp_data
  );
endinterface

// File: rtl/vx_dp_ram_ctrl.sv
// vx_dp_ram_ctrl: round-robin sharing of one 1W/1R byte-enabled RAM among NUM_REQS requesters
// Ports: clk, reset_n (async, active-low), bus (vx_dp_ram_ctrl_if.slave: write/read
// requests with one-hot grants, registered back-pressured read response), init_done
// (high once the post-reset sweep to INIT_VALUE has finished).
// Define VX_DP_RAM_CTRL_BYPASS_EN for write-first same-address read/write; read-first otherwise.
module vx_dp_ram_ctrl #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int SIZE     = 256,
  parameter int BYTEENW  = 4,
  parameter int ADDRW    = $clog2(SIZE),
  parameter logic [DATAW-1:0] INIT_VALUE = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  vx_dp_ram_ctrl_if.slave bus,
  output logic            init_done
);
  localparam int REQ_IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int LW = DATAW / BYTEENW;
  typedef enum logic {ST_INIT, ST_READY} state_t;
  state_t state_q, state_d;
  logic [ADDRW-1:0] init_cnt_q, init_cnt_d, mem_waddr, mem_raddr;
  logic [REQ_IDXW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx, rd_idx, rsp_idx_q, rsp_idx_d;
  logic rsp_valid_q, rsp_valid_d, init_done_q, init_done_d, wr_gnt, rd_gnt, rd_en, mem_we, init_last;
  logic [DATAW-1:0] rsp_data_q, rsp_data_d, mem_wdata, rd_word;
  logic [BYTEENW-1:0] mem_wbe;
  logic [ADDRW-1:0] wa [NUM_REQS];
  logic [ADDRW-1:0] ra [NUM_REQS];
  logic [DATAW-1:0] wd [NUM_REQS];
  logic [BYTEENW-1:0] wb [NUM_REQS];
  logic [DATAW-1:0] mem [SIZE];
  // Lowest requester at or above ptr wins; if none, wrap to the lowest overall.
  function automatic logic [REQ_IDXW:0] rr_pick(input logic [NUM_REQS-1:0] v, input logic [REQ_IDXW-1:0] ptr);
    logic [NUM_REQS-1:0] m;
    logic [REQ_IDXW:0] r;
    m = v & ~((NUM_REQS'(1) << ptr) - NUM_REQS'(1));
    if (m == '0) m = v;
    r = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) if (m[k]) r = {1'b1, REQ_IDXW'(k)};
    return r;
  endfunction
  function automatic logic [REQ_IDXW-1:0] ptr_next(input logic [REQ_IDXW-1:0] i);
    return (i == REQ_IDXW'(NUM_REQS - 1)) ? '0 : i + 1'b1;
  endfunction
  always_comb
    for (int k = 0; k < NUM_REQS; k++) begin
      wa[k] = bus.wr_addr[k*ADDRW +: ADDRW];
      ra[k] = bus.rd_addr[k*ADDRW +: ADDRW];
      wd[k] = bus.wr_data[k*DATAW +: DATAW];
      wb[k] = bus.wr_byteen[k*BYTEENW +: BYTEENW];
    end
  // A new read may only be granted when the response slot is empty or draining this cycle.
  assign rd_en = !rsp_valid_q || bus.rsp_ready;
  assign {wr_gnt, wr_idx} = (state_q == ST_READY) ? rr_pick(bus.wr_valid, wr_ptr_q) : '0;
  assign {rd_gnt, rd_idx} = (state_q == ST_READY && rd_en) ? rr_pick(bus.rd_valid, rd_ptr_q) : '0;
  assign bus.wr_ready  = wr_gnt ? NUM_REQS'(1) << wr_idx : '0;
  assign bus.rd_ready  = rd_gnt ? NUM_REQS'(1) << rd_idx : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_idx   = rsp_idx_q;
  assign bus.rsp_data  = rsp_data_q;
  assign init_done     = init_done_q;
  // The init sweep owns the write port until READY.
  always_comb begin
    mem_we    = state_q == ST_INIT || wr_gnt;
    mem_waddr = (state_q == ST_INIT) ? init_cnt_q : wa[wr_idx];
    mem_wdata = (state_q == ST_INIT) ? INIT_VALUE : wd[wr_idx];
    mem_wbe   = (state_q == ST_INIT) ? '1 : wb[wr_idx];
    mem_raddr = ra[rd_idx];
  end
`ifdef VX_DP_RAM_CTRL_BYPASS_EN
  always_comb begin
    rd_word = mem[mem_raddr];
    for (int b = 0; b < BYTEENW; b++)
      if (mem_we && mem_wbe[b] && mem_waddr == mem_raddr) rd_word[b*LW +: LW] = mem_wdata[b*LW +: LW];
  end
`else
  assign rd_word = mem[mem_raddr];
`endif
  always_comb begin
    init_last   = init_cnt_q == ADDRW'(SIZE - 1);
    state_d     = (state_q == ST_INIT && init_last) ? ST_READY : state_q;
    init_cnt_d  = (state_q == ST_INIT && !init_last) ? init_cnt_q + 1'b1 : init_cnt_q;
    init_done_d = init_done_q || (state_q == ST_INIT && init_last);
    wr_ptr_d    = wr_gnt ? ptr_next(wr_idx) : wr_ptr_q;
    rd_ptr_d    = rd_gnt ? ptr_next(rd_idx) : rd_ptr_q;
    rsp_valid_d = rd_gnt || (rsp_valid_q && !bus.rsp_ready);
    rsp_idx_d   = rd_gnt ? rd_idx : rsp_idx_q;
    rsp_data_d  = rd_gnt ? rd_word : rsp_data_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_data_q  <= rsp_data_d;
    end
  always_ff @(posedge clk)
    for (int b = 0; b < BYTEENW; b++)
      if (mem_we && mem_wbe[b]) mem[mem_waddr][b*LW +: LW] <= mem_wdata[b*LW +: LW];
endmodule

// File: tb/tb_vx_dp_ram_ctrl.sv
// tb_vx_dp_ram_ctrl: directed self-checking bench for vx_dp_ram_ctrl
module tb_vx_dp_ram_ctrl;
  localparam logic [31:0] IV = 32'h5A5A5A5A;
`ifdef VX_DP_RAM_CTRL_BYPASS_EN
  localparam logic [31:0] T5_EXP = 32'hB;
`else
  localparam logic [31:0] T5_EXP = 32'hA;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic init_done;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [7:0] wa [4] = '{default: '0};
  logic [7:0] ra [4] = '{default: '0};
  logic [31:0] wd [4] = '{default: '0};
  logic [3:0] wb [4] = '{default: '0};
  vx_dp_ram_ctrl_if #(.NUM_REQS(4), .DATAW(32), .BYTEENW(4), .ADDRW(8)) bus();
  vx_dp_ram_ctrl #(.NUM_REQS(4), .DATAW(32), .SIZE(256), .BYTEENW(4), .ADDRW(8), .INIT_VALUE(IV)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .init_done(init_done));
  always #5 clk = ~clk;
  always_comb begin
    bus.wr_addr   = {wa[3], wa[2], wa[1], wa[0]};
    bus.rd_addr   = {ra[3], ra[2], ra[1], ra[0]};
    bus.wr_data   = {wd[3], wd[2], wd[1], wd[0]};
    bus.wr_byteen = {wb[3], wb[2], wb[1], wb[0]};
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [1:0] i, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.wr_valid[i] = 1'b1;
    wa[i] = a;
    wd[i] = d;
    wb[i] = be;
  endtask
  task automatic rd(input logic [1:0] i, input logic [7:0] a);
    bus.rd_valid[i] = 1'b1;
    ra[i] = a;
  endtask
  task automatic idle();
    bus.wr_valid = '0;
    bus.rd_valid = '0;
  endtask
  // Called at the negedge where reset_n was released, with all requests held high.
  task automatic wait_init(input string tag);
    repeat (255) @(negedge clk);
    chk({tag, "_done_early"}, init_done, 0);
    chk({tag, "_wr_ready_init"}, bus.wr_ready, 0);
    chk({tag, "_rd_ready_init"}, bus.rd_ready, 0);
    idle();
    @(negedge clk);
    chk({tag, "_done"}, init_done, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bus.rsp_ready = 1'b1;
    bus.wr_valid = '1;
    bus.rd_valid = '1;
    #2;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_idx", bus.rsp_idx, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd_ready", bus.rd_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_init("init");
    // 1: read of the last address returns the init value
    rd(2, 8'hFF);
    #1 chk("t1_rd_ready", bus.rd_ready, 4'b0100);
    @(negedge clk);
    idle();
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_idx", bus.rsp_idx, 2);
    chk("t1_rsp_data", bus.rsp_data, IV);
    @(negedge clk);
    chk("t1_rsp_drain", bus.rsp_valid, 0);
    // 2: write round robin between 0 and 2, then byte-enabled merge
    wr(0, 8'd20, 32'h20, 4'hF);
    wr(2, 8'd21, 32'h21, 4'hF);
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("t2_wr_rr%0d", k), bus.wr_ready, (k % 2 == 1) ? 4'b0100 : 4'b0001);
      @(negedge clk);
    end
    idle();
    wr(1, 8'd5, 32'h11223344, 4'hF);
    #1 chk("t2_wr_full", bus.wr_ready, 4'b0010);
    @(negedge clk);
    idle();
    wr(3, 8'd5, 32'hDEADBEEF, 4'b0011);
    #1 chk("t2_wr_part", bus.wr_ready, 4'b1000);
    @(negedge clk);
    idle();
    rd(0, 8'd5);
    #1 chk("t2_rd_ready", bus.rd_ready, 4'b0001);
    @(negedge clk);
    idle();
    chk("t2_merge_data", bus.rsp_data, 32'h1122BEEF);
    chk("t2_merge_idx", bus.rsp_idx, 0);
    rd(3, 8'd20);
    #1 chk("t2_rd_ready3", bus.rd_ready, 4'b1000);
    @(negedge clk);
    idle();
    chk("t2_wr20_data", bus.rsp_data, 32'h20);
    chk("t2_wr20_idx", bus.rsp_idx, 3);
    // 3: four readers back to back, rsp_ready held high
    for (int k = 0; k < 4; k++) rd(2'(k), 8'(8'h30 + k));
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t3_rd_ready%0d", k), bus.rd_ready, 4'b0001 << (k % 4));
      @(negedge clk);
      chk($sformatf("t3_rsp_valid%0d", k), bus.rsp_valid, 1);
      chk($sformatf("t3_rsp_idx%0d", k), bus.rsp_idx, k % 4);
    end
    // 4: back-pressure holds the response and blocks new grants
    idle();
    bus.rsp_ready = 1'b0;
    rd(3, 8'd5);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("t4_rd_block%0d", k), bus.rd_ready, 0);
      @(negedge clk);
      chk($sformatf("t4_hold_valid%0d", k), bus.rsp_valid, 1);
      chk($sformatf("t4_hold_idx%0d", k), bus.rsp_idx, 0);
      chk($sformatf("t4_hold_data%0d", k), bus.rsp_data, IV);
    end
    bus.rsp_ready = 1'b1;
    #1 chk("t4_rd_release", bus.rd_ready, 4'b1000);
    @(negedge clk);
    idle();
    chk("t4_next_valid", bus.rsp_valid, 1);
    chk("t4_next_idx", bus.rsp_idx, 3);
    chk("t4_next_data", bus.rsp_data, 32'h1122BEEF);
    @(negedge clk);
    chk("t4_drain", bus.rsp_valid, 0);
    // 5: same-cycle write and read of one address
    wr(0, 8'd9, 32'hA, 4'hF);
    @(negedge clk);
    idle();
    wr(1, 8'd9, 32'hB, 4'hF);
    rd(2, 8'd9);
    #1 chk("t5_wr_ready", bus.wr_ready, 4'b0010);
    chk("t5_rd_ready", bus.rd_ready, 4'b0100);
    @(negedge clk);
    idle();
    chk("t5_collide_data", bus.rsp_data, T5_EXP);
    rd(1, 8'd9);
    @(negedge clk);
    idle();
    chk("t5_after_data", bus.rsp_data, 32'hB);
    chk("t5_after_idx", bus.rsp_idx, 1);
    // 6: reset mid-traffic
    rd(0, 8'd5);
    @(negedge clk);
    idle();
    chk("t6_pre_valid", bus.rsp_valid, 1);
    wr(0, 8'd40, 32'h40, 4'hF);
    rd(1, 8'd5);
    #1 chk("t6_pre_wr_ready", bus.wr_ready, 4'b0001);
    chk("t6_pre_rd_ready", bus.rd_ready, 4'b0010);
    #1 reset_n = 1'b0;
    #1 chk("t6_rst_valid", bus.rsp_valid, 0);
    chk("t6_rst_done", init_done, 0);
    chk("t6_rst_wr_ready", bus.wr_ready, 0);
    chk("t6_rst_rd_ready", bus.rd_ready, 0);
    bus.wr_valid = '1;
    bus.rd_valid = '1;
    @(negedge clk);
    reset_n = 1'b1;
    wait_init("rerun");
    wr(1, 8'd50, 32'h50, 4'hF);
    wr(2, 8'd51, 32'h51, 4'hF);
    rd(1, 8'd5);
    rd(2, 8'd5);
    #1 chk("t6_wr_ptr_reset", bus.wr_ready, 4'b0010);
    chk("t6_rd_ptr_reset", bus.rd_ready, 4'b0010);
    @(negedge clk);
    idle();
    chk("t6_swept_valid", bus.rsp_valid, 1);
    chk("t6_swept_idx", bus.rsp_idx, 1);
    chk("t6_swept_data", bus.rsp_data, IV);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
